// File: rtl/mandelbrot_frame_engine.sv
// -----------------------------------------------------------------------------
// mandelbrot_frame_engine
//   Scans a COLS x ROWS pixel grid over a runtime viewport (origin x0/y0, pixel
//   pitch step) and iterates z <- z^2 + c in signed fixed point (FRAC =
//   BITWIDTH-3 fraction bits), one iteration per clock. One result per pixel
//   is streamed out with frame/line markers.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             pulse: latch x0/y0/step/max_iter and begin a frame (IDLE only)
//   x0, y0, step      viewport origin and per-column/per-row increment of c
//   max_iter          iteration limit
//   busy              high from the cycle after an accepted start until the
//                     last pixel of the frame is accepted
//   out_valid/ready   result handshake
//   out_ctr           iterations completed before escape or limit
//   out_escaped       1 = |z|^2 >= 4 was reached, 0 = limit was hit
//   out_first/eol/last pixel (0,0) / last column / last pixel of frame
//   dbg_state         current FSM state (IDLE=0, INIT=1, ITER=2, HOLD=3)
//
// Handshake: a result is transferred on any rising edge where out_valid and
// out_ready are both 1. Once raised, out_valid and every out_* data/marker bit
// stay constant until that transfer; out_valid never drops without it.
// -----------------------------------------------------------------------------
module mandelbrot_frame_engine #(
   parameter int BITWIDTH = 11,
   parameter int CTRWIDTH = 7,
   parameter int COLS     = 16,
   parameter int ROWS     = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic signed [BITWIDTH-1:0] x0,
   input  logic signed [BITWIDTH-1:0] y0,
   input  logic signed [BITWIDTH-1:0] step,
   input  logic [CTRWIDTH-1:0]        max_iter,
   output logic                       busy,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CTRWIDTH-1:0]        out_ctr,
   output logic                       out_escaped,
   output logic                       out_first,
   output logic                       out_eol,
   output logic                       out_last,
   output logic [1:0]                 dbg_state
);

   localparam int FRAC = BITWIDTH - 3;
   localparam int PW   = 2 * BITWIDTH;      // full product width
   localparam int SW   = 2 * BITWIDTH + 1;  // sum/difference width, cannot overflow
   localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic signed [SW-1:0] ESC_LIM = SW'(4) << (2 * FRAC);

   typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, ITER = 2'd2, HOLD = 2'd3} state_t;

   state_t                      state_q, state_d;
   logic signed [BITWIDTH-1:0]  x0_q, x0_d, step_q, step_d;
   logic signed [BITWIDTH-1:0]  cx_q, cx_d, cy_q, cy_d, zx_q, zx_d, zy_q, zy_d;
   logic [CTRWIDTH-1:0]         max_q, max_d, ctr_q, ctr_d;
   logic [CW-1:0]               col_q, col_d;
   logic [RW-1:0]               row_q, row_d;
   logic                        busy_q, busy_d, valid_q, valid_d;
   logic [CTRWIDTH-1:0]         octr_q, octr_d;
   logic                        oesc_q, oesc_d, ofirst_q, ofirst_d;
   logic                        oeol_q, oeol_d, olast_q, olast_d;

   // Iteration datapath on the current z
   logic signed [PW-1:0]        sx, sy, sxy;
   logic signed [SW-1:0]        mag, diff, dbl;
   logic signed [BITWIDTH-1:0]  zx_nx, zy_nx;
   logic                        esc, at_eol, at_last_row;
   logic                        unused_bits;

   always_comb begin
      sx    = PW'(zx_q) * PW'(zx_q);
      sy    = PW'(zy_q) * PW'(zy_q);
      sxy   = PW'(zx_q) * PW'(zy_q);
      mag   = SW'(sx) + SW'(sy);
      diff  = SW'(sx) - SW'(sy);
      dbl   = SW'(sxy) <<< 1;
      esc   = (mag >= ESC_LIM);
      // (v >>> FRAC) truncated to BITWIDTH is exactly bits [FRAC +: BITWIDTH]
      zx_nx = diff[FRAC +: BITWIDTH] + cx_q;
      zy_nx = dbl[FRAC +: BITWIDTH] + cy_q;
   end

   assign unused_bits = ^{diff[SW-1:FRAC+BITWIDTH], diff[FRAC-1:0],
                          dbl[SW-1:FRAC+BITWIDTH], dbl[FRAC-1:0]};

   assign at_eol      = (col_q == CW'(COLS - 1));
   assign at_last_row = (row_q == RW'(ROWS - 1));

   always_comb begin
      state_d  = state_q;
      x0_d     = x0_q;
      step_d   = step_q;
      max_d    = max_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      zx_d     = zx_q;
      zy_d     = zy_q;
      ctr_d    = ctr_q;
      col_d    = col_q;
      row_d    = row_q;
      busy_d   = busy_q;
      valid_d  = valid_q;
      octr_d   = octr_q;
      oesc_d   = oesc_q;
      ofirst_d = ofirst_q;
      oeol_d   = oeol_q;
      olast_d  = olast_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               x0_d    = x0;
               step_d  = step;
               max_d   = max_iter;
               col_d   = '0;
               row_d   = '0;
               cx_d    = x0;
               cy_d    = y0;
               busy_d  = 1'b1;
               state_d = INIT;
            end
         end
         INIT: begin
            zx_d    = '0;
            zy_d    = '0;
            ctr_d   = '0;
            state_d = ITER;
         end
         ITER: begin
            // Escape wins over the limit when both hold on the same cycle
            if (esc || (ctr_q == max_q)) begin
               octr_d   = ctr_q;
               oesc_d   = esc;
               ofirst_d = (col_q == '0) && (row_q == '0);
               oeol_d   = at_eol;
               olast_d  = at_eol && at_last_row;
               valid_d  = 1'b1;
               state_d  = HOLD;
            end else begin
               zx_d  = zx_nx;
               zy_d  = zy_nx;
               ctr_d = ctr_q + CTRWIDTH'(1);
            end
         end
         HOLD: begin
            if (out_ready) begin
               valid_d = 1'b0;
               if (!at_eol) begin
                  col_d = col_q + CW'(1);
                  cx_d  = cx_q + step_q;
               end else begin
                  col_d = '0;
                  cx_d  = x0_q;
                  row_d = row_q + RW'(1);
                  cy_d  = cy_q + step_q;
               end
               if (at_eol && at_last_row) begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  state_d = INIT;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x0_q     <= '0;
         step_q   <= '0;
         max_q    <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         zx_q     <= '0;
         zy_q     <= '0;
         ctr_q    <= '0;
         col_q    <= '0;
         row_q    <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         octr_q   <= '0;
         oesc_q   <= 1'b0;
         ofirst_q <= 1'b0;
         oeol_q   <= 1'b0;
         olast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         x0_q     <= x0_d;
         step_q   <= step_d;
         max_q    <= max_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         zx_q     <= zx_d;
         zy_q     <= zy_d;
         ctr_q    <= ctr_d;
         col_q    <= col_d;
         row_q    <= row_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         octr_q   <= octr_d;
         oesc_q   <= oesc_d;
         ofirst_q <= ofirst_d;
         oeol_q   <= oeol_d;
         olast_q  <= olast_d;
      end
   end

   assign busy        = busy_q;
   assign out_valid   = valid_q;
   assign out_ctr     = octr_q;
   assign out_escaped = oesc_q;
   assign out_first   = ofirst_q;
   assign out_eol     = oeol_q;
   assign out_last    = olast_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_mandelbrot_frame_engine.sv
// -----------------------------------------------------------------------------
// Bench for mandelbrot_frame_engine. Expected pixel records
// {ctr, escaped, first, eol, last} are queued when a frame is started and
// popped by a monitor whenever the DUT transfers a result.
// -----------------------------------------------------------------------------
module tb_mandelbrot_frame_engine;

   localparam int BW   = 11;
   localparam int CTRW = 7;
   localparam int COLS = 16;
   localparam int ROWS = 12;
   localparam int FR   = BW - 3;
   localparam int W    = CTRW + 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic                 start, out_ready;
   logic signed [BW-1:0] x0, y0, step;
   logic [CTRW-1:0]      max_iter;
   logic                 busy, out_valid, out_escaped, out_first, out_eol, out_last;
   logic [CTRW-1:0]      out_ctr;
   logic [1:0]           dbg_state;

   mandelbrot_frame_engine #(
      .BITWIDTH(BW), .CTRWIDTH(CTRW), .COLS(COLS), .ROWS(ROWS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .x0(x0), .y0(y0), .step(step),
      .max_iter(max_iter), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_ctr(out_ctr), .out_escaped(out_escaped), .out_first(out_first),
      .out_eol(out_eol), .out_last(out_last), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int           total = 0;
   int           bad = 0;
   int           pop_count = 0;
   bit           mon_en = 1'b0;
   logic [W-1:0] mon_act, mon_exp;

   always @(negedge clk) begin
      if (mon_en && rst_n && out_valid && out_ready) begin
         mon_act = {out_ctr, out_escaped, out_first, out_eol, out_last};
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pixel_unexpected got=%h want=none", mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               bad++;
               $display("FAIL pixel_%0d got=%h want=%h (ctr,esc,first,eol,last)",
                        pop_count, mon_act, mon_exp);
            end
         end
         pop_count++;
      end
   end

   // Reference iteration in wide integers with explicit BW-bit wrap of z
   function automatic void model_pix(input int cx, input int cy, input int mx,
                                     output int ctr, output bit esc);
      int zx, zy, sx, sy, sxy;
      logic signed [BW-1:0] t;
      zx = 0; zy = 0; ctr = 0; esc = 1'b0;
      for (int k = 0; k <= mx; k++) begin
         sx = zx * zx; sy = zy * zy; sxy = zx * zy;
         if (sx + sy >= (4 << (2 * FR))) begin
            esc = 1'b1; ctr = k; return;
         end
         if (k == mx) begin
            ctr = k; return;
         end
         t  = BW'(((sx - sy) >>> FR) + cx); zx = t;
         t  = BW'(((2 * sxy) >>> FR) + cy); zy = t;
      end
   endfunction

   task automatic push_frame(input int fx0, input int fy0, input int fst, input int fmx,
                             input bit use_model, input int fix_ctr, input bit fix_esc);
      logic signed [BW-1:0] t;
      int cxi, cyi, ctr;
      bit esc;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            t = BW'(fx0 + c * fst); cxi = t;
            t = BW'(fy0 + r * fst); cyi = t;
            if (use_model) model_pix(cxi, cyi, fmx, ctr, esc);
            else begin ctr = fix_ctr; esc = fix_esc; end
            exp_q.push_back({CTRW'(ctr), esc, (c == 0 && r == 0), (c == COLS - 1),
                             (c == COLS - 1 && r == ROWS - 1)});
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input int fx0, input int fy0, input int fst, input int fmx);
      x0 = BW'(fx0); y0 = BW'(fy0); step = BW'(fst); max_iter = CTRW'(fmx);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_frame(input bit rnd, input bit noise);
      int n = 0;
      while (exp_q.size() > 0 && n < 40000) begin
         out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (noise && busy) begin
            start = ($urandom_range(0, 4) == 0);
            x0    = BW'($urandom);
            step  = BW'($urandom);
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
      end
      start = 1'b0;
      out_ready = 1'b1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL frame_timeout left=%0d want=0", exp_q.size());
         exp_q.delete();
      end
      tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_after_frame got=%b want=0", busy);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
      x0 = '0; y0 = '0; step = '0; max_iter = '0;
      #12;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      total++;
      if ({out_ctr, out_escaped, out_first, out_eol, out_last} !== '0) begin
         bad++;
         $display("FAIL reset_data got=%h want=0", {out_ctr, out_escaped, out_first, out_eol, out_last});
      end
      total++;
      if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
      #10 rst_n = 1'b1;
      tick();
      mon_en = 1'b1;
   endtask

   // c = 0: z stays 0, every pixel runs to the limit
   task automatic test_limit_frame();
      int n;
      pop_count = 0;
      out_ready = 1'b1;
      push_frame(0, 0, 0, 5, 1'b0, 5, 1'b0);
      kick(0, 0, 0, 5);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start got=%b want=1", busy); end
      wait_valid(n);
      // start edge + INIT + 6 ITER cycles (ctr 0..5) + HOLD register = 8 edges
      total++;
      if (n + 1 != 8) begin bad++; $display("FAIL first_latency got=%0d want=8", n + 1); end
      run_frame(1'b0, 1'b0);
      total++;
      if (pop_count != COLS * ROWS) begin
         bad++;
         $display("FAIL pixel_count got=%0d want=%0d", pop_count, COLS * ROWS);
      end
   endtask

   // c = 1.0: z = 0, 1, 2 -> |z|^2 = 4 tested at ctr=2
   task automatic test_escape_pos();
      push_frame(1 << FR, 0, 0, 127, 1'b0, 2, 1'b1);
      kick(1 << FR, 0, 0, 127);
      run_frame(1'b0, 1'b0);
   endtask

   // c = -2.0: z1 = -2 already has |z|^2 = 4, escape tested at ctr=1
   task automatic test_escape_neg();
      push_frame(-(2 << FR), 0, 0, 20, 1'b0, 1, 1'b1);
      kick(-(2 << FR), 0, 0, 20);
      run_frame(1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      int n;
      logic [W-1:0] held;
      out_ready = 1'b0;
      push_frame(0, 0, 0, 5, 1'b0, 5, 1'b0);
      kick(0, 0, 0, 5);
      wait_valid(n);
      held = {out_ctr, out_escaped, out_first, out_eol, out_last};
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (out_valid !== 1'b1 || dbg_state !== 2'd3 ||
             {out_ctr, out_escaped, out_first, out_eol, out_last} !== held) begin
            bad++;
            $display("FAIL stall_hold cyc=%0d got v=%b st=%0d d=%h want v=1 st=3 d=%h",
                     i, out_valid, dbg_state, {out_ctr, out_escaped, out_first, out_eol, out_last}, held);
         end
      end
      run_frame(1'b1, 1'b0);
   endtask

   // Full viewport vs model, random ready, spurious starts with junk config while busy
   task automatic test_reference_frame();
      push_frame(-(2 << FR), -(3 << (FR - 1)), 1 << (FR - 2), 31, 1'b1, 0, 1'b0);
      kick(-(2 << FR), -(3 << (FR - 1)), 1 << (FR - 2), 31);
      run_frame(1'b1, 1'b1);
   endtask

   task automatic test_reset_mid_frame();
      int n;
      out_ready = 1'b1;
      kick(0, 0, 0, 31);
      tick();
      total++;
      if (dbg_state !== 2'd2) begin bad++; $display("FAIL mid_state got=%0d want=2", dbg_state); end
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || dbg_state !== 2'd0 ||
          {out_ctr, out_escaped, out_first, out_eol, out_last} !== '0) begin
         bad++;
         $display("FAIL mid_reset got busy=%b v=%b st=%0d want 0 0 0", busy, out_valid, dbg_state);
      end
      #3 rst_n = 1'b1;
      tick();
      mon_en = 1'b1;
      push_frame(0, 0, 0, 5, 1'b0, 5, 1'b0);
      kick(0, 0, 0, 5);
      wait_valid(n);
      total++;
      if (out_valid !== 1'b1 || out_first !== 1'b1 || out_ctr !== CTRW'(5)) begin
         bad++;
         $display("FAIL restart_first got v=%b first=%b ctr=%0d want 1 1 5", out_valid, out_first, out_ctr);
      end
      run_frame(1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_limit_frame();
      test_escape_pos();
      test_escape_neg();
      test_backpressure();
      test_reference_frame();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
